portb_io_ctrl: RTL and testbench
================================

PORTB_IO_CTRL -- requirements
Module: portb_io_ctrl

Interface
REQ-001 Parameter BTN_ADDR, 16'h0FF0, BRAM word that receives debounced button state.
REQ-002 Parameter BALL_X_ADDR, 16'h0FF1; BALL_Y_ADDR, 16'h0FF2; P1_ADDR, 16'h0FF3; P2_ADDR, 16'h0FF4; BRAM words read each frame.
REQ-003 Parameter DEBOUNCE_CYCLES, 16'd50000, cycles a synchronized button must stay stable before acceptance.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 btn_raw  in  4  asynchronous push-buttons {p2_dn, p2_up, p1_dn, p1_up}.
REQ-007 frame_tick  in  1  one-cycle pulse at start of vertical blank.
REQ-008 q_b  in  16  BRAM port-B read data, synchronous read, valid the cycle after addr_b is presented.
REQ-009 addr_b  out  16  BRAM port-B address.
REQ-010 data_b  out  16  BRAM port-B write data.
REQ-011 we_b  out  1  BRAM port-B write enable.
REQ-012 ball_x, ball_y, paddle1_y, paddle2_y  out  16 each  frame snapshot for the display.
REQ-013 busy  out  1  high while a frame transaction is in progress.
REQ-014 snapshot_valid  out  1  one-cycle pulse when all four snapshot outputs update.

Function
REQ-015 Each btn_raw bit SHALL pass a 2-flop synchronizer, then a per-bit debounce counter; btn_db[i] changes only after the synchronized value differs from btn_db[i] for DEBOUNCE_CYCLES consecutive cycles; any bounce resets that counter to 0.
REQ-016 The FSM SHALL have states IDLE, WR_BTN, RD_BX, RD_BY, RD_P1, RD_P2, DONE, each lasting exactly one cycle except IDLE.
REQ-017 IDLE: addr_b=16'h0000, we_b=0; on frame_tick=1 go to WR_BTN next cycle.
REQ-018 WR_BTN: addr_b=BTN_ADDR, we_b=1, data_b={12'b0, btn_db}; next RD_BX.
REQ-019 RD_BX: addr_b=BALL_X_ADDR, we_b=0; next RD_BY.
REQ-020 RD_BY: addr_b=BALL_Y_ADDR; q_b captured into shadow ball_x; next RD_P1.
REQ-021 RD_P1: addr_b=P1_ADDR; q_b into shadow ball_y; next RD_P2.
REQ-022 RD_P2: addr_b=P2_ADDR; q_b into shadow paddle1_y; next DONE.
REQ-023 DONE: q_b into paddle2_y directly; shadow ball_x, ball_y, paddle1_y copied to outputs on the same edge; snapshot_valid=1 for this cycle only.
REQ-024 Snapshot outputs SHALL change only on the DONE edge, all four together; never partially updated.
REQ-025 Latency: frame_tick sampled in IDLE at edge N gives snapshot_valid high in cycle N+6 and outputs updated at the end of that cycle.
REQ-026 frame_tick while busy SHALL set a single pending flag (further ticks ignored); in DONE with pending set, next state is WR_BTN and pending clears; otherwise IDLE.
REQ-027 frame_tick coinciding with DONE SHALL count as pending.
REQ-028 busy = (state != IDLE); we_b SHALL be high only in WR_BTN; data_b SHALL be {12'b0, btn_db} in every state.
REQ-029 Button sampled into WR_BTN is btn_db at the start of the WR_BTN cycle; a debounce change during the transaction appears in the next frame's write.

Reset
REQ-030 reset=0 SHALL asynchronously force state IDLE, pending 0, synchronizers, debounce counters, btn_db, shadows and all snapshot outputs to 0, snapshot_valid 0, we_b 0, addr_b 16'h0000.
REQ-031 Reset asserted mid-transaction SHALL abort it with no snapshot update and no further BRAM write; first tick after release starts a full transaction.

Verification
REQ-032 BRAM model holds 0FF1..0FF4 = 0x0040, 0x0030, 0x0010, 0x0070; pulse frame_tick -> one write to 0FF0, reads in order 0FF1..0FF4, snapshot_valid 6 cycles later, outputs 0x0040/0x0030/0x0010/0x0070 together.
REQ-033 DEBOUNCE_CYCLES=4, hold btn_raw=4'b0001 stable -> btn_db=1 after 2+4 cycles; next frame writes 0x0001 to 0FF0; 3-cycle glitch -> btn_db unchanged.
REQ-034 Three frame_ticks during one transaction -> exactly one back-to-back follow-up transaction (WR_BTN immediately after DONE), then IDLE.
REQ-035 Change 0FF3 in the model between frames -> paddle1_y holds old value until the next DONE edge, then updates with the other three.
REQ-036 Assert reset in RD_P1 -> outputs 0, busy 0, we_b 0 immediately; release, tick -> full 7-state sequence and correct snapshot.
REQ-037 Idle with no tick for 1000 cycles -> we_b never asserted, snapshot_valid never asserted, outputs stable.

Source files
------------

// File: rtl/portb_io_ctrl.sv
// portb_io_ctrl: debounces the four push-buttons and, once per frame, writes them to BRAM
// port B and reads back ball/paddle words into a snapshot that updates all at once.
module portb_io_ctrl #(
    parameter logic [15:0] BTN_ADDR        = 16'h0FF0,
    parameter logic [15:0] BALL_X_ADDR     = 16'h0FF1,
    parameter logic [15:0] BALL_Y_ADDR     = 16'h0FF2,
    parameter logic [15:0] P1_ADDR         = 16'h0FF3,
    parameter logic [15:0] P2_ADDR         = 16'h0FF4,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  btn_raw,
    input  logic        frame_tick,
    input  logic [15:0] q_b,
    output logic [15:0] addr_b,
    output logic [15:0] data_b,
    output logic        we_b,
    output logic [15:0] ball_x,
    output logic [15:0] ball_y,
    output logic [15:0] paddle1_y,
    output logic [15:0] paddle2_y,
    output logic        busy,
    output logic        snapshot_valid
);

    typedef enum logic [2:0] {
        IDLE, WR_BTN, RD_BX, RD_BY, RD_P1, RD_P2, DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        pending;
    logic [3:0]  btn_sync1;
    logic [3:0]  btn_sync2;
    logic [3:0]  btn_db;
    logic [15:0] db_cnt [4];
    logic [15:0] shadow_bx;
    logic [15:0] shadow_by;
    logic [15:0] shadow_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_sync1 <= '0;
            btn_sync2 <= '0;
        end else begin
            btn_sync1 <= btn_raw;
            btn_sync2 <= btn_sync1;
        end
    end

    // A bit is accepted only after the synchronized value disagrees with btn_db for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement in between restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_db <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_sync2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    btn_db[i] <= btn_sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DONE)
                pending <= 1'b0;
            else if (frame_tick && state != IDLE)
                pending <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        addr_b     = 16'h0000;
        we_b       = 1'b0;
        case (state)
            IDLE:   if (frame_tick) state_next = WR_BTN;
            WR_BTN: begin
                addr_b     = BTN_ADDR;
                we_b       = 1'b1;
                state_next = RD_BX;
            end
            RD_BX:  begin
                addr_b     = BALL_X_ADDR;
                state_next = RD_BY;
            end
            RD_BY:  begin
                addr_b     = BALL_Y_ADDR;
                state_next = RD_P1;
            end
            RD_P1:  begin
                addr_b     = P1_ADDR;
                state_next = RD_P2;
            end
            RD_P2:  begin
                addr_b     = P2_ADDR;
                state_next = DONE;
            end
            DONE:   state_next = (pending || frame_tick) ? WR_BTN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign data_b         = {12'b0, btn_db};
    assign busy           = (state != IDLE);
    assign snapshot_valid = (state == DONE);

    // Read data lags the address by one cycle, so each state captures the word
    // requested by the state before it; the visible outputs move together in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_bx <= '0;
            shadow_by <= '0;
            shadow_p1 <= '0;
            ball_x    <= '0;
            ball_y    <= '0;
            paddle1_y <= '0;
            paddle2_y <= '0;
        end else begin
            case (state)
                RD_BY: shadow_bx <= q_b;
                RD_P1: shadow_by <= q_b;
                RD_P2: shadow_p1 <= q_b;
                DONE: begin
                    ball_x    <= shadow_bx;
                    ball_y    <= shadow_by;
                    paddle1_y <= shadow_p1;
                    paddle2_y <= q_b;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_portb_io_ctrl.sv
// tb_portb_io_ctrl: self-checking bench for portb_io_ctrl with a synchronous BRAM model,
// an access log and a queue of expected snapshots.
module tb_portb_io_ctrl;

    typedef struct packed {
        logic [15:0] bx;
        logic [15:0] by;
        logic [15:0] p1;
        logic [15:0] p2;
    } snap_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  btn_raw = 4'b0000;
    logic        frame_tick = 1'b0;
    logic [15:0] q_b = 16'h0000;
    logic [15:0] addr_b;
    logic [15:0] data_b;
    logic        we_b;
    logic [15:0] ball_x;
    logic [15:0] ball_y;
    logic [15:0] paddle1_y;
    logic [15:0] paddle2_y;
    logic        busy;
    logic        snapshot_valid;

    logic [15:0] mem [0:65535];
    logic        tb_we = 1'b0;
    logic [15:0] tb_waddr = 16'h0000;
    logic [15:0] tb_wdata = 16'h0000;

    snap_t exp_q[$];
    acc_t  log_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;

    portb_io_ctrl #(.DEBOUNCE_CYCLES(16'd4)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .frame_tick(frame_tick), .q_b(q_b),
        .addr_b(addr_b), .data_b(data_b), .we_b(we_b),
        .ball_x(ball_x), .ball_y(ball_y), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
        .busy(busy), .snapshot_valid(snapshot_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wdata;
        else if (we_b) mem[addr_b] <= data_b;
        q_b <= mem[addr_b];
    end

    always @(negedge clk) begin
        if (busy) log_q.push_back({we_b, addr_b, data_b});
    end

    task automatic set_mem(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic push_expected();
        exp_q.push_back({mem[16'h0FF1], mem[16'h0FF2], mem[16'h0FF3], mem[16'h0FF4]});
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    // Returns at the negedge of the cycle in which snapshot_valid is high.
    task automatic wait_snapshot(output int edges, output bit timed_out);
        edges = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (snapshot_valid) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_mem(16'h0000, 16'h0000);
        set_mem(16'h0FF0, 16'h0000);
        set_mem(16'h0FF1, 16'h0040);
        set_mem(16'h0FF2, 16'h0030);
        set_mem(16'h0FF3, 16'h0010);
        set_mem(16'h0FF4, 16'h0070);
        @(negedge clk); #1;
        n_cmp++;
        if ({busy, we_b, snapshot_valid} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: busy/we/valid=%b required 000", {busy, we_b, snapshot_valid});
        end
        n_cmp++;
        if (addr_b !== 16'h0000 || data_b !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_bus: addr=%h data=%h required 0000/0000", addr_b, data_b);
        end
        n_cmp++;
        if ({ball_x, ball_y, paddle1_y, paddle2_y} !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: %h %h %h %h required all 0000", ball_x, ball_y, paddle1_y, paddle2_y);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_frame();
        int    edges;
        bit    to;
        snap_t exp;
        log_q.delete();
        push_expected();
        pulse_tick();
        wait_snapshot(edges, to);
        n_cmp++;
        if (to || edges != 5) begin
            n_fail++;
            $display("[TB] FAIL frame_latency: edges=%0d timeout=%0d required edges=5", edges, to);
        end
        n_cmp++;
        if ({ball_x, ball_y, paddle1_y, paddle2_y} !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL frame_no_early_update: %h %h %h %h required all 0000", ball_x, ball_y, paddle1_y, paddle2_y);
        end
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        n_cmp++;
        if ({ball_x, ball_y, paddle1_y, paddle2_y} !== exp) begin
            n_fail++;
            $display("[TB] FAIL frame_snapshot: %h %h %h %h required %h", ball_x, ball_y, paddle1_y, paddle2_y, exp);
        end
        n_cmp++;
        if (log_q.size() != 6 || log_q[0] !== {1'b1, 16'h0FF0, 16'h0000} ||
            log_q[1] !== {1'b0, 16'h0FF1, 16'h0000} || log_q[2] !== {1'b0, 16'h0FF2, 16'h0000} ||
            log_q[3] !== {1'b0, 16'h0FF3, 16'h0000} || log_q[4] !== {1'b0, 16'h0FF4, 16'h0000} ||
            log_q[5].we !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL frame_bus_sequence: %0d accesses, first=%h required 6 accesses write 0FF0 then reads 0FF1..0FF4",
                     log_q.size(), (log_q.size() > 0) ? log_q[0] : 33'h0);
        end
    endtask

    task automatic test_debounce();
        int    edges;
        bit    to;
        snap_t exp;
        @(negedge clk);
        btn_raw = 4'b0001;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (data_b !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL debounce_early: data_b=%h required 0000", data_b);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (data_b !== 16'h0001) begin
            n_fail++;
            $display("[TB] FAIL debounce_accept: data_b=%h required 0001", data_b);
        end
        log_q.delete();
        push_expected();
        pulse_tick();
        wait_snapshot(edges, to);
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        n_cmp++;
        if (to || log_q.size() == 0 || log_q[0] !== {1'b1, 16'h0FF0, 16'h0001} || mem[16'h0FF0] !== 16'h0001) begin
            n_fail++;
            $display("[TB] FAIL debounce_write: mem[0FF0]=%h timeout=%0d required write of 0001", mem[16'h0FF0], to);
        end
        n_cmp++;
        if ({ball_x, ball_y, paddle1_y, paddle2_y} !== exp) begin
            n_fail++;
            $display("[TB] FAIL debounce_snapshot: %h %h %h %h required %h", ball_x, ball_y, paddle1_y, paddle2_y, exp);
        end
        @(negedge clk);
        btn_raw = 4'b0011;
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_raw = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_raw = 4'b0001;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (data_b !== 16'h0001) begin
            n_fail++;
            $display("[TB] FAIL debounce_glitch: data_b=%h required 0001", data_b);
        end
        btn_raw = 4'b0000;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (data_b !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL debounce_release: data_b=%h required 0000", data_b);
        end
    endtask

    task automatic test_update();
        int          bad;
        bit          to;
        logic [15:0] old_p1;
        snap_t       exp;
        old_p1 = paddle1_y;
        set_mem(16'h0FF3, 16'h0055);
        push_expected();
        pulse_tick();
        bad = 0;
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (paddle1_y !== old_p1) bad++;
            if (snapshot_valid) begin
                to = 1'b0;
                break;
            end
            @(posedge clk);
        end
        n_cmp++;
        if (to || bad != 0) begin
            n_fail++;
            $display("[TB] FAIL update_hold: early changes=%0d timeout=%0d required 0/0", bad, to);
        end
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        n_cmp++;
        if ({ball_x, ball_y, paddle1_y, paddle2_y} !== exp) begin
            n_fail++;
            $display("[TB] FAIL update_snapshot: %h %h %h %h required %h", ball_x, ball_y, paddle1_y, paddle2_y, exp);
        end
    endtask

    task automatic test_back_to_back();
        int    edges;
        bit    to1;
        bit    to2;
        snap_t exp;
        log_q.delete();
        push_expected();
        pulse_tick();
        push_expected();
        repeat (3) pulse_tick();
        wait_snapshot(edges, to1);
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        n_cmp++;
        if (to1 || {ball_x, ball_y, paddle1_y, paddle2_y} !== exp) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: %h %h %h %h timeout=%0d required %h", ball_x, ball_y, paddle1_y, paddle2_y, to1, exp);
        end
        n_cmp++;
        if (we_b !== 1'b1 || addr_b !== 16'h0FF0) begin
            n_fail++;
            $display("[TB] FAIL b2b_restart: we_b=%b addr_b=%h required 1/0FF0", we_b, addr_b);
        end
        wait_snapshot(edges, to2);
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        n_cmp++;
        if (to2 || {ball_x, ball_y, paddle1_y, paddle2_y} !== exp) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: %h %h %h %h timeout=%0d required %h", ball_x, ball_y, paddle1_y, paddle2_y, to2, exp);
        end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (log_q.size() != 12 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_count: accesses=%0d busy=%b required 12/0", log_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        int    edges;
        int    writes;
        bit    to;
        snap_t exp;
        log_q.delete();
        pulse_tick();
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (addr_b === 16'h0FF3) begin
                to = 1'b0;
                break;
            end
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (to || {busy, we_b, snapshot_valid} !== 3'b000 || addr_b !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL abort_ctrl: busy/we/valid=%b addr=%h timeout=%0d required 000/0000",
                     {busy, we_b, snapshot_valid}, addr_b, to);
        end
        n_cmp++;
        if ({ball_x, ball_y, paddle1_y, paddle2_y} !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL abort_outputs: %h %h %h %h required all 0000", ball_x, ball_y, paddle1_y, paddle2_y);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        writes = 0;
        foreach (log_q[i]) if (log_q[i].we) writes++;
        n_cmp++;
        if (writes != 1) begin
            n_fail++;
            $display("[TB] FAIL abort_writes: writes=%0d required 1", writes);
        end
        log_q.delete();
        push_expected();
        pulse_tick();
        wait_snapshot(edges, to);
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        n_cmp++;
        if (to || edges != 5 || {ball_x, ball_y, paddle1_y, paddle2_y} !== exp) begin
            n_fail++;
            $display("[TB] FAIL abort_recover: %h %h %h %h edges=%0d required %h edges=5",
                     ball_x, ball_y, paddle1_y, paddle2_y, edges, exp);
        end
        n_cmp++;
        if (log_q.size() != 6 || log_q[0].addr !== 16'h0FF0 || log_q[1].addr !== 16'h0FF1 ||
            log_q[2].addr !== 16'h0FF2 || log_q[3].addr !== 16'h0FF3 || log_q[4].addr !== 16'h0FF4) begin
            n_fail++;
            $display("[TB] FAIL abort_sequence: accesses=%0d required 6 in order 0FF0..0FF4", log_q.size());
        end
    endtask

    task automatic test_idle();
        int    we_seen;
        int    valid_seen;
        int    changed;
        snap_t held;
        held = {ball_x, ball_y, paddle1_y, paddle2_y};
        we_seen = 0;
        valid_seen = 0;
        changed = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (we_b !== 1'b0) we_seen++;
            if (snapshot_valid !== 1'b0) valid_seen++;
            if ({ball_x, ball_y, paddle1_y, paddle2_y} !== held) changed++;
        end
        n_cmp++;
        if (we_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL idle_we: cycles with we_b=%0d required 0", we_seen);
        end
        n_cmp++;
        if (valid_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL idle_valid: cycles with snapshot_valid=%0d required 0", valid_seen);
        end
        n_cmp++;
        if (changed != 0) begin
            n_fail++;
            $display("[TB] FAIL idle_stable: cycles with changed outputs=%0d required 0", changed);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_debounce();
        test_update();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
